// File: rtl/sodor_scratchpad_responder.sv
// Sodor scratchpad responder: B/H/W loads and stores on on-chip RAM with a fixed-latency response pipe.
// Optional misalignment trapping when SODOR_SCRATCH_MISALIGN_TRAP_EN is defined.
module sodor_scratchpad_responder #(
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_req_valid,
  input  logic [31:0] io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic        io_req_bits_fcn,
  input  logic [2:0]  io_req_bits_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_bits_data,
  output logic [31:0] io_resp_addr,
  output logic        io_resp_err
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  r_vld  [LATENCY];
  logic [31:0]           r_data [LATENCY];
  logic [31:0]           r_addr [LATENCY];
  logic                  r_err  [LATENCY];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_is_b;
  logic                  w_is_h;
  logic                  w_signed;
  logic                  w_misalign;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rword;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [31:0]           w_rdata;

  assign w_idx    = io_req_bits_addr[DEPTH_LOG2+1:2];
  assign w_is_b   = (io_req_bits_typ == 3'd1) || (io_req_bits_typ == 3'd5);
  assign w_is_h   = (io_req_bits_typ == 3'd2) || (io_req_bits_typ == 3'd6);
  assign w_signed = (io_req_bits_typ == 3'd1) || (io_req_bits_typ == 3'd2);
  assign w_rword  = r_mem[w_idx];

`ifdef SODOR_SCRATCH_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_h && io_req_bits_addr[0]) ||
                      (!w_is_b && !w_is_h && (io_req_bits_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = io_req_bits_data;
    w_rbyte = w_rword[7:0];
    w_rhalf = io_req_bits_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_rdata = w_rword;
    case (io_req_bits_addr[1:0])
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      2'd3:    w_rbyte = w_rword[31:24];
      default: w_rbyte = w_rword[7:0];
    endcase
    if (w_is_b) begin
      w_be    = 4'b0001 << io_req_bits_addr[1:0];
      w_wdata = {4{io_req_bits_data[7:0]}};
      w_rdata = {{24{w_signed & w_rbyte[7]}}, w_rbyte};
    end else if (w_is_h) begin
      w_be    = io_req_bits_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{io_req_bits_data[15:0]}};
      w_rdata = {{16{w_signed & w_rhalf[15]}}, w_rhalf};
    end
    // Writes and trapped accesses answer with zero data.
    if (io_req_bits_fcn || w_misalign) begin
      w_rdata = 32'h0;
    end
  end

  // RAM is not reset; reset_n only gates stores issued while in reset.
  always_ff @(posedge clock) begin
    if (reset_n && io_req_valid && io_req_bits_fcn && !w_misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Payload only advances with a valid bit, so idle cycles hold the outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_data[i] <= 32'h0;
        r_addr[i] <= 32'h0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      r_vld[0] <= io_req_valid;
      if (io_req_valid) begin
        r_data[0] <= w_rdata;
        r_addr[0] <= io_req_bits_addr;
        r_err[0]  <= w_misalign;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_data[i] <= r_data[i-1];
          r_addr[i] <= r_addr[i-1];
          r_err[i]  <= r_err[i-1];
        end
      end
    end
  end

  assign io_resp_valid     = r_vld[LATENCY-1];
  assign io_resp_bits_data = r_data[LATENCY-1];
  assign io_resp_addr      = r_addr[LATENCY-1];
  assign io_resp_err       = r_err[LATENCY-1];

endmodule

// File: tb/tb_sodor_scratchpad_responder.sv
// tb/tb_sodor_scratchpad_responder.sv - scoreboard bench for sodor_scratchpad_responder
module tb_sodor_scratchpad_responder;

  localparam int LAT = 3;
  localparam logic [2:0] T_B = 3'd1, T_H = 3'd2, T_W = 3'd3, T_BU = 3'd5, T_HU = 3'd6;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_req_valid = 1'b0;
  logic [31:0] io_req_bits_addr = 32'h0;
  logic [31:0] io_req_bits_data = 32'h0;
  logic        io_req_bits_fcn = 1'b0;
  logic [2:0]  io_req_bits_typ = 3'd0;
  logic        io_resp_valid;
  logic [31:0] io_resp_bits_data;
  logic [31:0] io_resp_addr;
  logic        io_resp_err;

  sodor_scratchpad_responder #(.DEPTH_LOG2(16), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_req_valid(io_req_valid), .io_req_bits_addr(io_req_bits_addr),
    .io_req_bits_data(io_req_bits_data), .io_req_bits_fcn(io_req_bits_fcn),
    .io_req_bits_typ(io_req_bits_typ),
    .io_resp_valid(io_resp_valid), .io_resp_bits_data(io_resp_bits_data),
    .io_resp_addr(io_resp_addr), .io_resp_err(io_resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   edges = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clock) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation, on time.
  always @(negedge clock) begin
    if (reset_n) begin
      if (io_resp_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got addr 0x%08h data 0x%08h expected no response", io_resp_addr, io_resp_bits_data);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_edge", edges, mon_e.due);
          chk("resp_data", io_resp_bits_data, mon_e.d);
          chk("resp_addr", io_resp_addr, mon_e.a);
          chk("resp_err", {31'h0, io_resp_err}, {31'h0, mon_e.e});
        end
      end else if (sb.size() > 0 && sb[0].due < edges) begin
        mon_e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_resp: got no response expected addr 0x%08h by edge %0d", mon_e.a, mon_e.due);
      end
    end
  end

  task automatic req(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e);
    exp_t x;
    @(negedge clock);
    io_req_valid     = 1'b1;
    io_req_bits_fcn  = fcn;
    io_req_bits_typ  = typ;
    io_req_bits_addr = addr;
    io_req_bits_data = data;
    x.d = exp_d; x.a = addr; x.e = exp_e; x.due = edges + LAT;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      io_req_valid = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'h0, io_resp_valid}, 32'h0);
    chk("rst_data", io_resp_bits_data, 32'h0);
    chk("rst_addr", io_resp_addr, 32'h0);
    chk("rst_err", {31'h0, io_resp_err}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    req(1'b1, T_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req(1'b0, T_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    req(1'b1, T_B,  32'h8000_0013, 32'h0000_00A5, 32'h0, 1'b0);
    req(1'b0, T_B,  32'h8000_0013, 32'h0, 32'hFFFF_FFA5, 1'b0);
    req(1'b0, T_BU, 32'h8000_0013, 32'h0, 32'h0000_00A5, 1'b0);
    req(1'b0, T_W,  32'h8000_0010, 32'h0, 32'hA5AD_BEEF, 1'b0);
    req(1'b0, T_B,  32'h8000_0010, 32'h0, 32'hFFFF_FFEF, 1'b0);
    idle(2);
    req(1'b1, T_H,  32'h8000_0012, 32'h1234_8001, 32'h0, 1'b0);
    req(1'b0, T_H,  32'h8000_0012, 32'h0, 32'hFFFF_8001, 1'b0);
    req(1'b0, T_HU, 32'h8000_0012, 32'h0, 32'h0000_8001, 1'b0);
    req(1'b0, 3'd7, 32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);
    req(1'b0, T_W,  32'h0000_0010, 32'h0, 32'h8001_BEEF, 1'b0);
    idle(1);

    for (int i = 0; i < 8; i++)
      if (i != 4) req(1'b1, T_W, 32'h8000_0000 + 4*i, 32'hA000_0000 | i, 32'h0, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++)
      req(1'b0, T_W, 32'h8000_0000 + 4*i, 32'h0,
          (i == 4) ? 32'h8001_BEEF : (32'hA000_0000 | i), 1'b0);
    idle(4);

    req(1'b1, T_W, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
`ifdef SODOR_SCRATCH_MISALIGN_TRAP_EN
    req(1'b1, T_W, 32'h8000_0021, 32'h1234_5678, 32'h0, 1'b1);
    req(1'b0, T_W, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);
    req(1'b0, T_H, 32'h8000_0011, 32'h0, 32'h0, 1'b1);
`else
    req(1'b1, T_W, 32'h8000_0021, 32'h1234_5678, 32'h0, 1'b0);
    req(1'b0, T_W, 32'h8000_0020, 32'h0, 32'h1234_5678, 1'b0);
    req(1'b0, T_H, 32'h8000_0011, 32'h0, 32'hFFFF_BEEF, 1'b0);
`endif
    idle(5);

    // Two reads in flight, then an asynchronous reset between edges.
    req(1'b0, T_W, 32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);
    req(1'b0, T_W, 32'h8000_0014, 32'h0, 32'hA000_0005, 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    io_req_valid = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", {31'h0, io_resp_valid}, 32'h0);
    chk("async_rst_data", io_resp_bits_data, 32'h0);
    chk("async_rst_addr", io_resp_addr, 32'h0);
    @(negedge clock);
    io_req_valid     = 1'b1;
    io_req_bits_fcn  = 1'b1;
    io_req_bits_typ  = T_W;
    io_req_bits_addr = 32'h8000_0010;
    io_req_bits_data = 32'hFFFF_FFFF;
    @(negedge clock);
    io_req_valid = 1'b0;
    reset_n = 1'b1;
    idle(6);
    req(1'b0, T_W, 32'h8000_0010, 32'h0, 32'h8001_BEEF, 1'b0);
    req(1'b0, T_W, 32'h8000_0014, 32'h0, 32'hA000_0005, 1'b0);
    idle(1);

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clock);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got no response expected addr 0x%08h", mon_e.a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
